// File: rtl/cache_sequencer.sv
// Job sequencer for the stream cache: loads stream words, clears the hash table, runs the hash
// core, then hands the cache to the next stage. Optional PROC watchdog via CACHE_SEQ_TIMEOUT_EN.
module cache_sequencer #(
  parameter int unsigned LENGTH_ARRAY     = 100,
  parameter int unsigned BIT_ON_TAILS     = 7,
  parameter int unsigned DATA_INDEX_WIDTH = 32,
`ifdef CACHE_SEQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES   = 4096,
`endif
  localparam int unsigned LH   = 1 << BIT_ON_TAILS,
  localparam int unsigned LA_W = $clog2(LENGTH_ARRAY),
  localparam int unsigned LH_W = $clog2(2 * LH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        src_valid,
  input  logic [DATA_INDEX_WIDTH-1:0] src_data,
  output logic                        src_ready,
  output logic                        WrInitStreamData,
  output logic [LA_W-1:0]             AddrInitStreamData,
  output logic [DATA_INDEX_WIDTH-1:0] InitStreamData,
  output logic                        WrInitHash,
  output logic [LH_W-1:0]             AddrInitHashOccurr,
  output logic                        hc_start,
  input  logic                        hc_done,
  output logic                        DataRequest,
  input  logic                        CacheEnough,
  input  logic                        next_ack,
  output logic [2:0]                  state
`ifdef CACHE_SEQ_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StClear = 3'd2,
    StProc  = 3'd3,
    StXfer  = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [LA_W-1:0]             beat_q, beat_d;
  logic [LH_W-1:0]             clr_q, clr_d;
  logic                        wr_q, wr_d;
  logic [LA_W-1:0]             waddr_q, waddr_d;
  logic [DATA_INDEX_WIDTH-1:0] wdata_q, wdata_d;
  logic                        hc_start_q, hc_start_d;
  logic                        done_q, done_d;

`ifdef CACHE_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    clr_d      = clr_q;
    wr_d       = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    hc_start_d = 1'b0;
    done_d     = 1'b0;
`ifdef CACHE_SEQ_TIMEOUT_EN
    tmo_d      = '0;
    err_d      = err_q;
`endif
    case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse belongs to the finished job and is dropped.
        if (start && !done_q) begin
          state_d = StLoad;
          beat_d  = '0;
`ifdef CACHE_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (src_valid) begin
          wr_d    = 1'b1;
          waddr_d = beat_q + LA_W'(1);
          wdata_d = src_data;
          if (beat_q == LA_W'(LENGTH_ARRAY - 1)) begin
            state_d = StClear;
            beat_d  = '0;
            clr_d   = '0;
          end else begin
            beat_d = beat_q + LA_W'(1);
          end
        end
      end
      StClear: begin
        if (clr_q == LH_W'(LH - 1)) begin
          state_d    = StProc;
          clr_d      = '0;
          hc_start_d = 1'b1;
        end else begin
          clr_d = clr_q + LH_W'(1);
        end
      end
      StProc: begin
        if (hc_done) begin
          state_d = StXfer;
`ifdef CACHE_SEQ_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end
      StXfer: begin
        if (CacheEnough && next_ack) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      clr_q      <= '0;
      wr_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hc_start_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef CACHE_SEQ_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      clr_q      <= clr_d;
      wr_q       <= wr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hc_start_q <= hc_start_d;
      done_q     <= done_d;
`ifdef CACHE_SEQ_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  assign state              = state_q;
  assign busy               = (state_q != StIdle);
  assign src_ready          = (state_q == StLoad);
  assign DataRequest        = (state_q == StXfer);
  assign done               = done_q;
  assign hc_start           = hc_start_q;
  assign WrInitStreamData   = wr_q;
  assign AddrInitStreamData = waddr_q;
  assign InitStreamData     = wdata_q;
  assign WrInitHash         = (state_q == StClear);
  assign AddrInitHashOccurr = WrInitHash ? clr_q + LH_W'(1) : '0;
`ifdef CACHE_SEQ_TIMEOUT_EN
  assign timeout_err        = err_q;
`endif

endmodule

// File: tb/tb_cache_sequencer.sv
// Randomized bench for cache_sequencer: a monitor logs every cache-init write and pulse, and each
// job is compared against the stream it was fed. Covers the timeout when CACHE_SEQ_TIMEOUT_EN is set.
module tb_cache_sequencer;
  localparam int unsigned LEN  = 100;
  localparam int unsigned LH   = 128;
  localparam int unsigned DW   = 32;
  localparam int unsigned LA_W = 7;
  localparam int unsigned LH_W = 8;

  logic            clk, rst, start, busy, done;
  logic            src_valid, src_ready;
  logic [DW-1:0]   src_data;
  logic            WrInitStreamData, WrInitHash;
  logic [LA_W-1:0] AddrInitStreamData;
  logic [DW-1:0]   InitStreamData;
  logic [LH_W-1:0] AddrInitHashOccurr;
  logic            hc_start, hc_done, DataRequest, CacheEnough, next_ack;
  logic [2:0]      state;
`ifdef CACHE_SEQ_TIMEOUT_EN
  logic            timeout_err;
`endif

`ifdef CACHE_SEQ_TIMEOUT_EN
  cache_sequencer #(.TIMEOUT_CYCLES(16)) dut (
`else
  cache_sequencer dut (
`endif
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .src_valid         (src_valid),
    .src_data          (src_data),
    .src_ready         (src_ready),
    .WrInitStreamData  (WrInitStreamData),
    .AddrInitStreamData(AddrInitStreamData),
    .InitStreamData    (InitStreamData),
    .WrInitHash        (WrInitHash),
    .AddrInitHashOccurr(AddrInitHashOccurr),
    .hc_start          (hc_start),
    .hc_done           (hc_done),
    .DataRequest       (DataRequest),
    .CacheEnough       (CacheEnough),
    .next_ack          (next_ack),
    .state             (state)
`ifdef CACHE_SEQ_TIMEOUT_EN
    ,
    .timeout_err       (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Observed cache-init traffic and pulses for the current job.
  int            wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            hash_addr_q[$];
  int            done_cnt = 0;
  int            hc_start_cnt = 0;
  logic [DW-1:0] words[LEN];

  always @(negedge clk) begin
    if (WrInitStreamData) begin
      wr_addr_q.push_back(int'(AddrInitStreamData));
      wr_data_q.push_back(InitStreamData);
    end
    if (WrInitHash) hash_addr_q.push_back(int'(AddrInitHashOccurr));
    if (done) done_cnt++;
    if (hc_start) hc_start_cnt++;
    check("busy_map", busy, state != 3'd0);
    check("ready_map", src_ready, state == 3'd1);
    check("dreq_map", DataRequest, state == 3'd4);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, src_ready, 0);
    check({tag, "_wrs"}, WrInitStreamData, 0);
    check({tag, "_addrs"}, AddrInitStreamData, 0);
    check({tag, "_datas"}, InitStreamData, 0);
    check({tag, "_wrh"}, WrInitHash, 0);
    check({tag, "_addrh"}, AddrInitHashOccurr, 0);
    check({tag, "_hcs"}, hc_start, 0);
    check({tag, "_dreq"}, DataRequest, 0);
  endtask

  task automatic start_job();
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    hash_addr_q.delete();
    done_cnt     = 0;
    hc_start_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_to_load", state, 1);
  endtask

  // mode 0: valid always, 1: every other cycle, else random.
  task automatic load_stream(input int mode);
    int idx = 0;
    int guard = 0;
    bit tog = 1'b0;
    bit v;
    while (idx < LEN && guard < 1000) begin
      @(negedge clk);
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      src_valid = v;
      src_data  = v ? words[idx] : $urandom;
      hc_done   = ($urandom_range(0, 7) == 0);
      if (v && src_ready) idx++;
    end
    check("load_beats", idx, LEN);
    @(negedge clk);
    src_valid = 1'b0;
    hc_done   = 1'b0;
    check("ready_drop", src_ready, 0);
    check("load_to_clear", state, 2);
  endtask

  task automatic proc_and_xfer(input int hc_delay, input int ack_delay);
    int g = 0;
    while (!hc_start && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("hc_start_seen", hc_start, 1);
    check("hc_start_in_proc", state, 3);
    repeat (hc_delay) @(negedge clk);
    check("proc_waits", state, 3);
    hc_done = 1'b1;
    @(negedge clk);
    hc_done  = 1'b0;
    check("proc_to_xfer", state, 4);
    next_ack = 1'b1;
    @(negedge clk);
    check("ack_alone_ignored", state, 4);
    next_ack    = 1'b0;
    CacheEnough = 1'b1;
    for (int i = 0; i < ack_delay; i++) begin
      start = (i == 0);
      @(negedge clk);
      check("xfer_dreq_held", DataRequest, 1);
      check("xfer_hold", state, 4);
    end
    start    = 1'b0;
    next_ack = 1'b1;
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_idle", state, 0);
    check("done_dreq_low", DataRequest, 0);
    CacheEnough = 1'b0;
    next_ack    = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_with_done_ignored", state, 0);
    check("done_one_cycle", done, 0);
  endtask

  task automatic verify_job();
    check("stream_count", wr_addr_q.size(), LEN);
    for (int i = 0; i < wr_addr_q.size() && i < LEN; i++) begin
      check("stream_addr", wr_addr_q[i], i + 1);
      check("stream_data", wr_data_q[i], words[i]);
    end
    check("hash_count", hash_addr_q.size(), LH);
    for (int i = 0; i < hash_addr_q.size() && i < LH; i++) check("hash_addr", hash_addr_q[i], i + 1);
    check("done_count", done_cnt, 1);
    check("hc_start_count", hc_start_cnt, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < LEN; i++) words[i] = $urandom;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
    hc_done = 1'b0; CacheEnough = 1'b0; next_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
`ifdef CACHE_SEQ_TIMEOUT_EN
    check("reset_tmo_err", timeout_err, 0);
`endif
    rst = 1'b0;

    // Handshakes from downstream must not move an idle block.
    hc_done = 1'b1; CacheEnough = 1'b1; next_ack = 1'b1;
    @(negedge clk);
    check("idle_ignores_inputs", state, 0);
    hc_done = 1'b0; CacheEnough = 1'b0; next_ack = 1'b0;

    // Full job with data equal to beat index.
    for (int i = 0; i < LEN; i++) words[i] = DW'(i + 1);
    start_job();
    load_stream(0);
    proc_and_xfer(10, 3);
    verify_job();

    // Toggling source valid.
    fill_random();
    start_job();
    load_stream(1);
    proc_and_xfer($urandom_range(1, 15), 2);
    verify_job();

    // Reset in the middle of the hash clear.
    fill_random();
    start_job();
    load_stream(2);
    begin
      int g = 0;
      while (!(WrInitHash && AddrInitHashOccurr == 8'd50) && g < 400) begin
        @(negedge clk);
        g++;
      end
      check("clear50_seen", AddrInitHashOccurr, 50);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("abort");
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, 0);

    // Restart after abort, random valid, long ack delay.
    fill_random();
    start_job();
    load_stream(2);
    proc_and_xfer(10, 20);
    verify_job();

`ifdef CACHE_SEQ_TIMEOUT_EN
    fill_random();
    start_job();
    load_stream(0);
    begin
      int g = 0;
      int n = 0;
      while (!hc_start && g < 400) begin
        @(negedge clk);
        g++;
      end
      while (state == 3'd3 && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("tmo_proc_cycles", n, 16);
    end
    check("tmo_idle", state, 0);
    check("tmo_err_set", timeout_err, 1);
    check("tmo_no_done", done_cnt, 0);
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", timeout_err, 1);
    start_job();
    check("tmo_err_cleared", timeout_err, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
